// File: rtl/obs_spawn_sched.sv
// Four-slot falling-obstacle scheduler: LFSR-placed spawns on a level-dependent
// frame interval, per-frame fall, bottom-exit miss detection and hit clearing.
module obs_spawn_sched #(
  parameter int unsigned MAX_X     = 640,
  parameter int unsigned MAX_Y     = 480,
  parameter int unsigned OBS_SIZE  = 20,
  parameter int unsigned OBS_V     = 5,
  parameter int unsigned SPAWN_Y   = 16,
  parameter int unsigned BASE_INT  = 60,
  parameter logic [9:0]  LFSR_SEED = 10'h2A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refr_tick,
  input  logic        run,
  input  logic [1:0]  level,
  input  logic        hit_valid,
  input  logic [1:0]  hit_slot,
  output logic [3:0]  obs_valid,
  output logic [39:0] obs_x,
  output logic [39:0] obs_y,
  output logic        spawn,
  output logic        miss,
  output logic [2:0]  active_cnt
);

  localparam int unsigned NSLOT = 4;
  localparam int unsigned CW    = 10;
  localparam int unsigned FW    = 6;
  localparam int unsigned X_LIM = MAX_X - OBS_SIZE;
  localparam int unsigned Y_LIM = MAX_Y - OBS_SIZE;

  logic [CW-1:0]    r_lfsr;
  logic [FW-1:0]    r_fcnt;
  logic [NSLOT-1:0] r_valid;
  logic [CW-1:0]    r_x [NSLOT];
  logic [CW-1:0]    r_y [NSLOT];
  logic             r_spawn;
  logic             r_miss;
  logic [2:0]       r_cnt;

  logic [CW-1:0]    w_lfsr_nxt;
  logic [FW-1:0]    w_interval;
  logic             w_due;
  logic [CW-1:0]    w_spawn_x;
  logic [CW-1:0]    w_step;
  logic [CW-1:0]    w_ymove [NSLOT];
  logic             w_hit;
  logic             w_found;
  logic [FW-1:0]    w_fcnt_nxt;
  logic [NSLOT-1:0] w_valid_nxt;
  logic [CW-1:0]    w_x_nxt [NSLOT];
  logic [CW-1:0]    w_y_nxt [NSLOT];
  logic             w_spawn_nxt;
  logic             w_miss_nxt;
  logic [2:0]       w_cnt_nxt;

  // Next-state: hits override movement; spawn only targets slots empty at cycle start
  always_comb begin
    w_lfsr_nxt  = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    w_interval  = FW'(BASE_INT - 15 * 32'(level));
    w_due       = refr_tick && (r_fcnt >= (w_interval - FW'(1)));
    w_spawn_x   = (r_lfsr <= CW'(X_LIM)) ? r_lfsr : (r_lfsr - CW'(X_LIM + 1));
    w_step      = CW'(OBS_V) + CW'(level);
    w_hit       = 1'b0;
    w_found     = 1'b0;
    w_fcnt_nxt  = r_fcnt;
    w_valid_nxt = r_valid;
    w_spawn_nxt = 1'b0;
    w_miss_nxt  = 1'b0;
    w_cnt_nxt   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      w_x_nxt[i]  = r_x[i];
      w_y_nxt[i]  = r_y[i];
      w_ymove[i]  = r_y[i] + w_step;
    end

    if (!run) begin
      w_valid_nxt = '0;
      w_fcnt_nxt  = '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        w_hit = hit_valid && (hit_slot == 2'(i)) && r_valid[i];
        if (w_hit) begin
          w_valid_nxt[i] = 1'b0;
        end else if (refr_tick && r_valid[i]) begin
          if (w_ymove[i] > CW'(Y_LIM)) begin
            w_valid_nxt[i] = 1'b0;
            w_miss_nxt     = 1'b1;
          end else begin
            w_y_nxt[i] = w_ymove[i];
          end
        end
      end

      if (refr_tick) begin
        w_fcnt_nxt = w_due ? '0 : (r_fcnt + FW'(1));
      end

      if (w_due) begin
        for (int i = 0; i < NSLOT; i++) begin
          if (!r_valid[i] && !w_found) begin
            w_found        = 1'b1;
            w_valid_nxt[i] = 1'b1;
            w_x_nxt[i]     = w_spawn_x;
            w_y_nxt[i]     = CW'(SPAWN_Y);
            w_spawn_nxt    = 1'b1;
          end
        end
      end
    end

    for (int i = 0; i < NSLOT; i++) begin
      w_cnt_nxt = w_cnt_nxt + 3'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr  <= LFSR_SEED;
      r_fcnt  <= '0;
      r_valid <= '0;
      r_spawn <= 1'b0;
      r_miss  <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      r_lfsr  <= w_lfsr_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_valid <= w_valid_nxt;
      r_spawn <= w_spawn_nxt;
      r_miss  <= w_miss_nxt;
      r_cnt   <= w_cnt_nxt;
      for (int i = 0; i < NSLOT; i++) begin
        r_x[i] <= w_x_nxt[i];
        r_y[i] <= w_y_nxt[i];
      end
    end
  end

  always_comb begin
    obs_x = '0;
    obs_y = '0;
    for (int i = 0; i < NSLOT; i++) begin
      obs_x[CW*i +: CW] = r_x[i];
      obs_y[CW*i +: CW] = r_y[i];
    end
  end

  assign obs_valid  = r_valid;
  assign spawn      = r_spawn;
  assign miss       = r_miss;
  assign active_cnt = r_cnt;

endmodule

// File: tb/tb_obs_spawn_sched.sv
// Directed bench for obs_spawn_sched; spawn x is predicted by an LFSR model
// that tracks the clock count since reset release.
module tb_obs_spawn_sched;

  localparam logic [9:0] SEED = 10'h2A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        refr_tick = 1'b0;
  logic        run = 1'b0;
  logic [1:0]  level = 2'd0;
  logic        hit_valid = 1'b0;
  logic [1:0]  hit_slot = 2'd0;
  logic [3:0]  obs_valid;
  logic [39:0] obs_x;
  logic [39:0] obs_y;
  logic        spawn;
  logic        miss;
  logic [2:0]  active_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int bad;
  int quiet_bad;
  logic [9:0] m_lfsr, m_prev, last_x;
  logic [9:0] ex_x [4];

  obs_spawn_sched dut (
    .clk(clk), .rst(rst), .refr_tick(refr_tick), .run(run), .level(level),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .obs_valid(obs_valid),
    .obs_x(obs_x), .obs_y(obs_y), .spawn(spawn), .miss(miss), .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  // x^10+x^7+1 reference sequence; m_prev holds the value seen by the last edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
  end

  function automatic logic [9:0] map_x(input logic [9:0] v);
    return (v <= 10'd620) ? v : (v - 10'd621);
  endfunction

  task automatic cyc(input logic t, input logic h, input logic [1:0] s);
    @(negedge clk);
    refr_tick = t; hit_valid = h; hit_slot = s;
    @(negedge clk);
    refr_tick = 1'b0; hit_valid = 1'b0;
    last_x = map_x(m_prev);
  endtask

  task automatic period();
    level = 2'd0;
    repeat (14) begin
      cyc(1'b1, 1'b0, 2'd0);
      if (spawn !== 1'b0 || miss !== 1'b0) quiet_bad++;
    end
    level = 2'd3;
    cyc(1'b1, 1'b0, 2'd0);
    level = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (obs_valid !== 4'd0) begin n_err++; $display("FAIL rst_valid got %b exp 0000", obs_valid); end
    n_cmp++; if (obs_x !== 40'd0) begin n_err++; $display("FAIL rst_x got %h exp 0", obs_x); end
    n_cmp++; if (obs_y !== 40'd0) begin n_err++; $display("FAIL rst_y got %h exp 0", obs_y); end
    n_cmp++; if (spawn !== 1'b0 || miss !== 1'b0) begin n_err++; $display("FAIL rst_pulses got spawn=%b miss=%b exp 0", spawn, miss); end
    n_cmp++; if (active_cnt !== 3'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", active_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_first_spawn();
    run = 1'b1; level = 2'd0; bad = 0;
    for (int k = 1; k <= 59; k++) begin
      cyc(1'b1, 1'b0, 2'd0);
      if (spawn !== 1'b0 || obs_valid !== 4'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL early_spawn got %0d bad ticks exp 0", bad); end
    cyc(1'b1, 1'b0, 2'd0);
    ex_x[0] = last_x;
    n_cmp++; if (spawn !== 1'b1) begin n_err++; $display("FAIL spawn60_pulse got %b exp 1", spawn); end
    n_cmp++; if (obs_valid !== 4'b0001) begin n_err++; $display("FAIL spawn60_valid got %b exp 0001", obs_valid); end
    n_cmp++; if (obs_y[9:0] !== 10'd16) begin n_err++; $display("FAIL spawn60_y got %0d exp 16", obs_y[9:0]); end
    n_cmp++; if (obs_x[9:0] !== last_x) begin n_err++; $display("FAIL spawn60_x got %0d exp %0d", obs_x[9:0], last_x); end
    n_cmp++; if (obs_x[9:0] > 10'd620) begin n_err++; $display("FAIL spawn60_xrange got %0d exp <=620", obs_x[9:0]); end
    n_cmp++; if (active_cnt !== 3'd1) begin n_err++; $display("FAIL spawn60_cnt got %0d exp 1", active_cnt); end
    @(negedge clk);
    n_cmp++; if (spawn !== 1'b0) begin n_err++; $display("FAIL spawn_one_cycle got %b exp 0", spawn); end
  endtask

  task automatic test_fall_miss();
    int ey;
    int slot;
    logic exp_sp;
    level = 2'd3; slot = 1;
    for (int k = 1; k <= 57; k++) begin
      cyc(1'b1, 1'b0, 2'd0);
      ey = (k <= 55) ? (16 + 8 * k) : 456;
      exp_sp = (k == 15 || k == 30 || k == 45);
      n_cmp++; if (obs_y[9:0] !== 10'(ey)) begin n_err++; $display("FAIL fall_y0 tick %0d got %0d exp %0d", k, obs_y[9:0], ey); end
      n_cmp++; if (obs_valid[0] !== (k <= 55)) begin n_err++; $display("FAIL fall_v0 tick %0d got %b exp %b", k, obs_valid[0], (k <= 55)); end
      n_cmp++; if (miss !== (k == 56)) begin n_err++; $display("FAIL fall_miss tick %0d got %b exp %b", k, miss, (k == 56)); end
      n_cmp++; if (spawn !== exp_sp) begin n_err++; $display("FAIL fall_spawn tick %0d got %b exp %b", k, spawn, exp_sp); end
      if (exp_sp) begin
        ex_x[slot] = last_x;
        n_cmp++; if (obs_x[10*slot +: 10] !== last_x) begin n_err++; $display("FAIL fall_spawn_x slot %0d got %0d exp %0d", slot, obs_x[10*slot +: 10], last_x); end
        slot++;
      end
      if (k == 56) begin
        @(negedge clk);
        n_cmp++; if (miss !== 1'b0) begin n_err++; $display("FAIL miss_single got %b exp 0", miss); end
      end
    end
    n_cmp++; if (active_cnt !== 3'd3) begin n_err++; $display("FAIL fall_cnt got %0d exp 3", active_cnt); end
    n_cmp++; if (obs_y !== {10'd112, 10'd232, 10'd352, 10'd456}) begin n_err++; $display("FAIL fall_all_y got %h exp %h", obs_y, {10'd112, 10'd232, 10'd352, 10'd456}); end
  endtask

  task automatic test_hit();
    cyc(1'b1, 1'b1, 2'd2);
    n_cmp++; if (obs_valid !== 4'b1010) begin n_err++; $display("FAIL hit_tick_valid got %b exp 1010", obs_valid); end
    n_cmp++; if (obs_y !== {10'd120, 10'd232, 10'd360, 10'd456}) begin n_err++; $display("FAIL hit_tick_y got %h exp %h", obs_y, {10'd120, 10'd232, 10'd360, 10'd456}); end
    n_cmp++; if (miss !== 1'b0 || spawn !== 1'b0) begin n_err++; $display("FAIL hit_tick_pulses got miss=%b spawn=%b exp 0", miss, spawn); end
    cyc(1'b0, 1'b1, 2'd3);
    n_cmp++; if (obs_valid !== 4'b0010) begin n_err++; $display("FAIL hit3_valid got %b exp 0010", obs_valid); end
    cyc(1'b0, 1'b1, 2'd3);
    n_cmp++; if (obs_valid !== 4'b0010) begin n_err++; $display("FAIL hit_empty_valid got %b exp 0010", obs_valid); end
    n_cmp++; if (obs_y !== {10'd120, 10'd232, 10'd360, 10'd456}) begin n_err++; $display("FAIL hit_empty_y got %h exp %h", obs_y, {10'd120, 10'd232, 10'd360, 10'd456}); end
    n_cmp++; if (active_cnt !== 3'd1) begin n_err++; $display("FAIL hit_empty_cnt got %0d exp 1", active_cnt); end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({obs_valid, obs_x, obs_y, active_cnt} !== 87'd0) begin n_err++; $display("FAIL async_rst got v=%b x=%h y=%h c=%0d exp 0", obs_valid, obs_x, obs_y, active_cnt); end
    for (int i = 0; i < 4; i++) ex_x[i] = 10'd0;
    @(negedge clk);
    rst = 1'b1; level = 2'd3; bad = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc(1'b1, 1'b0, 2'd0);
      if (spawn !== 1'b0 || obs_valid !== 4'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rst_early_spawn got %0d bad ticks exp 0", bad); end
    cyc(1'b1, 1'b0, 2'd0);
    ex_x[0] = last_x;
    n_cmp++; if (spawn !== 1'b1 || obs_valid !== 4'b0001) begin n_err++; $display("FAIL rst_spawn15 got spawn=%b v=%b exp 1/0001", spawn, obs_valid); end
    n_cmp++; if (obs_x[9:0] !== last_x) begin n_err++; $display("FAIL rst_spawn15_x got %0d exp %0d", obs_x[9:0], last_x); end
  endtask

  task automatic test_free_and_spawn();
    repeat (14) cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 2'd0);
    n_cmp++; if (spawn !== 1'b1) begin n_err++; $display("FAIL free_spawn_pulse got %b exp 1", spawn); end
    n_cmp++; if (obs_valid !== 4'b0010) begin n_err++; $display("FAIL free_spawn_valid got %b exp 0010", obs_valid); end
    n_cmp++; if (obs_y[19:0] !== {10'd16, 10'd128}) begin n_err++; $display("FAIL free_spawn_y got %h exp %h", obs_y[19:0], {10'd16, 10'd128}); end
    n_cmp++; if (obs_x[19:0] !== {last_x, ex_x[0]}) begin n_err++; $display("FAIL free_spawn_x got %h exp %h", obs_x[19:0], {last_x, ex_x[0]}); end
    ex_x[1] = last_x;
  endtask

  task automatic test_full_drop();
    quiet_bad = 0;
    period();
    ex_x[0] = last_x;
    n_cmp++; if (spawn !== 1'b1 || obs_valid !== 4'b0011) begin n_err++; $display("FAIL fill_a got spawn=%b v=%b exp 1/0011", spawn, obs_valid); end
    n_cmp++; if (obs_x[9:0] !== last_x) begin n_err++; $display("FAIL fill_a_x got %0d exp %0d", obs_x[9:0], last_x); end
    period();
    ex_x[2] = last_x;
    n_cmp++; if (spawn !== 1'b1 || obs_valid !== 4'b0111) begin n_err++; $display("FAIL fill_b got spawn=%b v=%b exp 1/0111", spawn, obs_valid); end
    period();
    ex_x[3] = last_x;
    n_cmp++; if (spawn !== 1'b1 || obs_valid !== 4'b1111 || active_cnt !== 3'd4) begin n_err++; $display("FAIL fill_c got spawn=%b v=%b c=%0d exp 1/1111/4", spawn, obs_valid, active_cnt); end
    period();
    n_cmp++; if (spawn !== 1'b0) begin n_err++; $display("FAIL drop_spawn got %b exp 0", spawn); end
    n_cmp++; if (obs_valid !== 4'b1111 || active_cnt !== 3'd4) begin n_err++; $display("FAIL drop_state got v=%b c=%0d exp 1111/4", obs_valid, active_cnt); end
    n_cmp++; if (obs_y !== {10'd94, 10'd172, 10'd328, 10'd250}) begin n_err++; $display("FAIL drop_y got %h exp %h", obs_y, {10'd94, 10'd172, 10'd328, 10'd250}); end
    n_cmp++; if (quiet_bad !== 0) begin n_err++; $display("FAIL fill_quiet got %0d bad ticks exp 0", quiet_bad); end
    cyc(1'b0, 1'b1, 2'd1);
    n_cmp++; if (obs_valid !== 4'b1101 || active_cnt !== 3'd3) begin n_err++; $display("FAIL drop_hit got v=%b c=%0d exp 1101/3", obs_valid, active_cnt); end
    level = 2'd3; bad = 0;
    repeat (14) begin
      cyc(1'b1, 1'b0, 2'd0);
      if (spawn !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL fcnt_reload got %0d early spawns exp 0", bad); end
    cyc(1'b1, 1'b0, 2'd0);
    ex_x[1] = last_x;
    n_cmp++; if (spawn !== 1'b1 || obs_valid !== 4'b1111) begin n_err++; $display("FAIL refill got spawn=%b v=%b exp 1/1111", spawn, obs_valid); end
    n_cmp++; if (obs_y !== {10'd214, 10'd292, 10'd16, 10'd370}) begin n_err++; $display("FAIL refill_y got %h exp %h", obs_y, {10'd214, 10'd292, 10'd16, 10'd370}); end
  endtask

  task automatic test_run_stop_reset();
    cyc(1'b0, 1'b1, 2'd0);
    n_cmp++; if (obs_valid !== 4'b1110 || active_cnt !== 3'd3) begin n_err++; $display("FAIL stop_pre got v=%b c=%0d exp 1110/3", obs_valid, active_cnt); end
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs_valid !== 4'd0 || active_cnt !== 3'd0) begin n_err++; $display("FAIL stop_clear got v=%b c=%0d exp 0/0", obs_valid, active_cnt); end
    n_cmp++; if (obs_y !== {10'd214, 10'd292, 10'd16, 10'd370}) begin n_err++; $display("FAIL stop_y_hold got %h exp %h", obs_y, {10'd214, 10'd292, 10'd16, 10'd370}); end
    n_cmp++; if (obs_x !== {ex_x[3], ex_x[2], ex_x[1], ex_x[0]}) begin n_err++; $display("FAIL stop_x_hold got %h exp %h", obs_x, {ex_x[3], ex_x[2], ex_x[1], ex_x[0]}); end
    cyc(1'b1, 1'b0, 2'd0);
    n_cmp++; if (spawn !== 1'b0 || miss !== 1'b0 || obs_valid !== 4'd0) begin n_err++; $display("FAIL stop_tick got spawn=%b miss=%b v=%b exp 0", spawn, miss, obs_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({obs_valid, obs_x, obs_y, spawn, miss, active_cnt} !== 89'd0) begin n_err++; $display("FAIL stop_rst got v=%b x=%h y=%h c=%0d exp 0", obs_valid, obs_x, obs_y, active_cnt); end
    @(negedge clk);
    rst = 1'b1; run = 1'b1; level = 2'd3; bad = 0;
    repeat (14) begin
      cyc(1'b1, 1'b0, 2'd0);
      if (spawn !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL post_rst_early got %0d exp 0", bad); end
    cyc(1'b1, 1'b0, 2'd0);
    n_cmp++; if (spawn !== 1'b1 || obs_x[9:0] !== last_x) begin n_err++; $display("FAIL lfsr_reseed got spawn=%b x=%0d exp 1/%0d", spawn, obs_x[9:0], last_x); end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_fall_miss();
    test_hit();
    test_reset_midframe();
    test_free_and_spawn();
    test_full_drop();
    test_run_stop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/obs_spawn_sched.md
OBS_SPAWN_SCHED -- requirements
Module: obs_spawn_sched

Interface
REQ-001 SHALL have parameter MAX_X, default 640, screen width in pixels.
REQ-002 SHALL have parameter MAX_Y, default 480, screen height in pixels.
REQ-003 SHALL have parameter OBS_SIZE, default 20, obstacle edge length in pixels.
REQ-004 SHALL have parameter OBS_V, default 5, base fall speed in pixels/frame.
REQ-005 SHALL have parameter SPAWN_Y, default 16, top-edge y of a newly spawned obstacle (below the text row).
REQ-006 SHALL have parameter BASE_INT, default 60, spawn interval in frames at level 0.
REQ-007 SHALL have parameter LFSR_SEED, default 10'h2A5, nonzero LFSR reset value.
REQ-008 SHALL have port clk, input, 1, pixel clock; single clock domain.
REQ-009 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-010 SHALL have port refr_tick, input, 1, one-cycle pulse once per frame.
REQ-011 SHALL have port run, input, 1, game running; 0 = stopped.
REQ-012 SHALL have port level, input, 2, difficulty level 0..3.
REQ-013 SHALL have port hit_valid, input, 1, collision report strobe.
REQ-014 SHALL have port hit_slot, input, 2, slot index hit by the shot.
REQ-015 SHALL have port obs_valid, output, 4, per-slot occupied flag.
REQ-016 SHALL have port obs_x, output, 40, slot i left x in bits [10i+9:10i].
REQ-017 SHALL have port obs_y, output, 40, slot i top y in bits [10i+9:10i].
REQ-018 SHALL have port spawn, output, 1, one-cycle pulse when a slot is allocated.
REQ-019 SHALL have port miss, output, 1, one-cycle pulse when one or more obstacles exit the bottom.
REQ-020 SHALL have port active_cnt, output, 3, number of occupied slots (0..4).

Function
REQ-021 All outputs SHALL be registered; every effect described below SHALL be visible the cycle after the triggering input.
REQ-022 A 10-bit Fibonacci LFSR (x^10+x^7+1) SHALL advance every clk regardless of run.
REQ-023 Spawn x SHALL be lfsr when lfsr<=MAX_X-OBS_SIZE (620), else lfsr-(MAX_X-OBS_SIZE+1); the result SHALL always lie in 0..620.
REQ-024 Interval SHALL be BASE_INT-15*level (60/45/30/15 frames) and SHALL be evaluated with the current level on every tick.
REQ-025 Frame counter fcnt (6 bit): on refr_tick with run=1, if fcnt>=interval-1 then fcnt<=0 and a spawn attempt occurs; else fcnt<=fcnt+1.
REQ-026 Spawn attempt SHALL allocate the lowest-index slot whose obs_valid was 0 at the start of the cycle: valid<=1, x<=REQ-023 value, y<=SPAWN_Y, spawn pulse.
REQ-027 Spawn attempt with all 4 slots valid SHALL be dropped: no spawn pulse, fcnt still reloads to 0.
REQ-028 On refr_tick with run=1, each slot valid at cycle start and not spawned/hit this cycle SHALL take y<=y+OBS_V+level.
REQ-029 If that new y > MAX_Y-OBS_SIZE (460), the slot SHALL be freed (valid<=0, y holds the old value) and miss SHALL pulse; simultaneous exits SHALL produce a single miss pulse.
REQ-030 hit_valid=1 with run=1 and a valid hit_slot SHALL clear that slot; a hit on an invalid slot SHALL be ignored.
REQ-031 Hit and refr_tick on the same slot in the same cycle: the hit SHALL win; no movement and no miss for that slot.
REQ-032 A slot freed in a cycle (by hit or exit) SHALL NOT be reallocated in that same cycle.
REQ-033 run=0 SHALL synchronously clear all obs_valid and fcnt, and suppress spawn and miss; obs_x/obs_y SHALL hold.
REQ-034 x/y of invalid slots SHALL hold their last values.
REQ-035 active_cnt SHALL equal the popcount of the registered obs_valid.
REQ-036 Outside refr_tick only hits SHALL change state (apart from the LFSR).

Reset
REQ-037 rst=0 SHALL asynchronously set: obs_valid=0, obs_x=0, obs_y=0, fcnt=0, lfsr=LFSR_SEED, spawn=0, miss=0, active_cnt=0.
REQ-038 Reset mid-frame SHALL discard all slots; after release, the first spawn SHALL occur on the interval-th refr_tick with run=1.

Verification
REQ-039 Setup: run=1, level=0, 60 ticks -> spawn on tick 60, slot 0 valid, y=16, x in 0..620, active_cnt=1.
REQ-040 Setup: level=3, one obstacle, 57 further ticks -> y rises 8 per tick; at tick where y would exceed 460 -> valid=0, single miss pulse.
REQ-041 Setup: 4 slots full, spawn due -> no spawn pulse, fcnt=0, active_cnt stays 4.
REQ-042 Stimulus: hit_slot=2 at the same cycle as refr_tick -> slot 2 cleared, y unchanged, no miss; hit on empty slot 3 -> no change.
REQ-043 Stimulus: slot 0 freed in the same cycle as a spawn with slot 1 free -> slot 1 allocated, slot 0 stays free.
REQ-044 Stimulus: run drops to 0 with 3 active, then rst pulse -> valid=0 next cycle, then all outputs 0; LFSR returns to 10'h2A5.
